// File: rtl/adsr_envelope_if.sv
// ADSR envelope bus: tick/note controls, envelope settings, sample in/out.
// master = voice controller / oscillator side, slave = adsr_envelope.
interface adsr_envelope_if #(
    parameter int LEVEL_W  = 16,
    parameter int SAMPLE_W = 16
);
    logic                       get_next_sample;
    logic                       trigger;
    logic                       gate;
    logic [LEVEL_W-1:0]         attack_step;
    logic [LEVEL_W-1:0]         decay_step;
    logic [LEVEL_W-1:0]         sustain_level;
    logic [LEVEL_W-1:0]         release_step;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic signed [SAMPLE_W-1:0] sample_out;
    logic [LEVEL_W-1:0]         env_level;
    logic                       active;

    modport master (
        output get_next_sample, trigger, gate, attack_step, decay_step,
               sustain_level, release_step, sample_in,
        input  sample_out, env_level, active
    );

    modport slave (
        input  get_next_sample, trigger, gate, attack_step, decay_step,
               sustain_level, release_step, sample_in,
        output sample_out, env_level, active
    );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR amplitude envelope. Advances one step per sample tick and
// scales the oscillator sample by the pre-update envelope level for the DAC.
// Optional macro ADSR_EXP_RELEASE_EN: exponential release using
// release_step[3:0] as a shift; otherwise linear release by release_step.
module adsr_envelope #(
    parameter int LEVEL_W  = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    adsr_envelope_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } state_t;

    localparam logic [LEVEL_W-1:0] FULL = '1;

    state_t                     state_q, state_d;
    logic [LEVEL_W-1:0]         level_q, level_d;
    logic signed [SAMPLE_W-1:0] out_q, out_d;
    logic                       pend_q, pend_d;

    logic [LEVEL_W:0]           att_sum;
    logic [LEVEL_W-1:0]         att_level;
    logic [LEVEL_W:0]           dec_diff;
    logic [LEVEL_W-1:0]         rel_level;
    logic signed [SAMPLE_W+LEVEL_W:0] product;

`ifdef ADSR_EXP_RELEASE_EN
    logic [LEVEL_W-1:0] rel_dec;

    // Exponential release; forced minimum decrement of 1 guarantees reaching 0.
    always_comb begin
        rel_dec = level_q >> bus.release_step[3:0];
        if (rel_dec == '0 && level_q != '0) begin
            rel_dec = {{(LEVEL_W-1){1'b0}}, 1'b1};
        end
        rel_level = level_q - rel_dec;
    end
`else
    logic [LEVEL_W:0] rel_diff;

    // Linear release, saturating at 0.
    always_comb begin
        rel_diff  = {1'b0, level_q} - {1'b0, bus.release_step};
        rel_level = rel_diff[LEVEL_W] ? '0 : rel_diff[LEVEL_W-1:0];
    end
`endif

    // Next-state, level, output and trigger-latch computation.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        out_d   = out_q;
        pend_d  = pend_q | bus.trigger;

        att_sum   = {1'b0, level_q} + {1'b0, bus.attack_step};
        att_level = att_sum[LEVEL_W] ? FULL : att_sum[LEVEL_W-1:0];
        dec_diff  = {1'b0, level_q} - {1'b0, bus.decay_step};
        product   = $signed(bus.sample_in) * $signed({1'b0, level_q});

        if (bus.get_next_sample) begin
            pend_d = 1'b0;
            out_d  = SAMPLE_W'(product >>> LEVEL_W);
            if (pend_q || bus.trigger) begin
                // Retrigger keeps the current level so the attack is click-free.
                level_d = att_level;
                state_d = (att_level == FULL) ? DECAY : ATTACK;
            end else if (!bus.gate &&
                         (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
                level_d = rel_level;
                state_d = (rel_level == '0) ? IDLE : RELEASE;
            end else begin
                case (state_q)
                    ATTACK: begin
                        level_d = att_level;
                        if (att_level == FULL) state_d = DECAY;
                    end
                    DECAY: begin
                        if (level_q <= bus.sustain_level || dec_diff[LEVEL_W] ||
                            dec_diff[LEVEL_W-1:0] <= bus.sustain_level) begin
                            level_d = bus.sustain_level;
                            state_d = SUSTAIN;
                        end else begin
                            level_d = dec_diff[LEVEL_W-1:0];
                        end
                    end
                    SUSTAIN: level_d = bus.sustain_level;
                    RELEASE: begin
                        level_d = rel_level;
                        if (rel_level == '0) state_d = IDLE;
                    end
                    default: level_d = '0;
                endcase
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            out_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            out_q   <= out_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.sample_out = out_q;
    assign bus.env_level  = level_q;
    assign bus.active     = (state_q != IDLE);
endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR amplitude envelope between the sine oscillator (sin_gen) and the 1st-order delta-sigma DAC.
- Runs once per sample tick (the same get_next_sample strobe that advances the oscillator).
- Scales the oscillator's 16-bit sample by a 16-bit envelope level and presents the result as the DAC's current_sample input.

Parameters:
- LEVEL_W, 16, envelope level width. Full scale = 2^LEVEL_W-1.
- SAMPLE_W, 16, sample width in and out.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- get_next_sample  input  1  single-cycle sample tick.
- trigger  input  1  single-cycle note-on pulse.
- gate  input  1  held high while the note is held.
- attack_step  input  16  level increment per tick in ATTACK.
- decay_step  input  16  level decrement per tick in DECAY.
- sustain_level  input  16  SUSTAIN target level.
- release_step  input  16  level decrement per tick in RELEASE (release shift in [3:0] when the optional feature is enabled).
- sample_in  input  SAMPLE_W  signed two's-complement oscillator sample, stable on the tick cycle.
- sample_out  output  SAMPLE_W  signed scaled sample, to the DAC.
- env_level  output  LEVEL_W  current envelope level, unsigned.
- active  output  1  high whenever state != IDLE.

Behaviour:
- One clock domain; reset is synchronous, active-high.
- Reset values: state=IDLE, env_level=0, sample_out=0, active=0, trigger_pending=0.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE. Encoded internally.
- trigger_pending:
  - Set on any cycle where trigger=1.
  - Cleared on the tick that consumes it.
  - A trigger pulse on a tick cycle is consumed on that same tick.
- State and level change only on cycles with get_next_sample=1. Between ticks, all registers hold.
- Per-tick evaluation, priority order:
  1. trigger_pending or trigger → ATTACK. env_level is NOT reset; attack continues from the current level (retrigger is click-free).
  2. Else, gate=0 while in ATTACK, DECAY or SUSTAIN → RELEASE. This tick's level update uses release arithmetic.
  3. Else, per-state update:
     - ATTACK: level = min(level + attack_step, 0xFFFF). On reaching 0xFFFF → DECAY.
     - DECAY: level = max(level - decay_step, sustain_level). On reaching sustain_level → SUSTAIN. If level is already <= sustain_level on entry, go → SUSTAIN with level = sustain_level.
     - SUSTAIN: level = sustain_level, tracking live changes to the input.
     - RELEASE: level = max(level - release_step, 0). On reaching 0 → IDLE.
     - IDLE: level stays 0.
- Step values:
  - A step of 0 holds the level in that state indefinitely. This is legal and not an error.
  - Add/subtract use a 17-bit intermediate, then saturate. No wrap-around is permitted.
- Output path:
  - On a tick, sample_out <= (signed sample_in × {1'b0, env_level_before_update}) >>> LEVEL_W, arithmetic shift.
  - Uses the 33-bit signed product; truncate, do not round.
  - sample_out is visible the cycle after the tick and holds until the next tick.
  - env_level=0xFFFF with sample_in=-32768 gives -32768. With env_level=0, the output is 0.
- active is combinational from state.
- Reset asserted mid-note forces IDLE and level 0 on the next edge, regardless of tick.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: RELEASE uses level = level - (level >> release_step[3:0]). When the shifted decrement is 0 and level > 0, level is decremented by 1 so RELEASE always terminates at 0 → IDLE.
- Undefined: linear release as described in Behaviour; the full 16-bit release_step is used.

Test Plan:
- Reset, then 10 ticks with gate=0 and no trigger → state IDLE, env_level=0, sample_out=0, active=0.
- Setup: attack_step=0x4000, decay_step=0x1000, sustain_level=0x8000, sample_in=0x4000 constant. Stimulus: trigger, hold gate=1. Required response:
  - Levels 0x4000, 0x8000, 0xC000, 0xFFFF, then DECAY 0xEFFF … 0x8000, then SUSTAIN.
  - sample_out in SUSTAIN = 0x2000.
- In SUSTAIN at 0x8000 with release_step=0x2000, drop gate → levels 0x6000, 0x4000, 0x2000, 0x0000, then IDLE. active falls the cycle after the final tick.
- Trigger pulse between ticks at level 0x6000 in RELEASE → next tick enters ATTACK, level 0x6000+attack_step, with no drop to 0.
- Trigger and gate=0 on the same tick → ATTACK wins. The next tick with gate=0 enters RELEASE.
- sample_in=0x8000 (-32768) at level 0xFFFF → sample_out=0x8000. sample_in=0x7FFF at level 0x0001 → sample_out=0x0000. With ADSR_EXP_RELEASE_EN and release_step=4 from 0x0010 → 0x000F, 0x000E, … down to 0, then IDLE.
